// File: rtl/pss_correlator_tdm.sv
// Time-multiplexed PSS correlator: one sample window against NUM_SEQ local
// sequences, MULT_PAR complex MACs per sequence per cycle, |corr|^2 out.
module pss_correlator_tdm #(
  parameter int IN_DW = 32,
  parameter int TAP_DW = 32,
  parameter int OUT_DW = 32,
  parameter int PSS_LEN = 128,
  parameter int NUM_SEQ = 3,
  parameter int MULT_PAR = 4,
  parameter int OUT_SHIFT = 0,
  parameter logic [NUM_SEQ*PSS_LEN*TAP_DW-1:0] PSS_LOCAL = '0,
  localparam int UW = (NUM_SEQ > 1) ? $clog2(NUM_SEQ) : 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [IN_DW-1:0]  s_axis_in_tdata,
  input  logic              s_axis_in_tvalid,
  output logic              s_axis_in_tready,
  output logic [OUT_DW-1:0] m_axis_out_tdata,
  output logic [UW-1:0]     m_axis_out_tuser,
  output logic              m_axis_out_tlast,
  output logic              m_axis_out_tvalid
);

  localparam int IH = IN_DW / 2;
  localparam int TH = TAP_DW / 2;
  localparam int K = PSS_LEN / MULT_PAR;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int IW = (PSS_LEN > 1) ? $clog2(PSS_LEN) : 1;
  localparam int ACC_DW = IH + TH + $clog2(PSS_LEN) + 1;
  localparam int MW = 2 * ACC_DW;

  typedef enum logic [1:0] {IDLE, MAC, MAG, OUT} state_t;

  state_t            state;
  logic [KW-1:0]     k;
  logic [UW-1:0]     j;
  logic [IN_DW-1:0]  dline [PSS_LEN];
  logic [OUT_DW-1:0] sat [NUM_SEQ];
  logic              accept;

  assign s_axis_in_tready = (state == IDLE) && !reset_i;
  assign accept = s_axis_in_tvalid && s_axis_in_tready;

  for (genvar s = 0; s < NUM_SEQ; s++) begin : g_seq
    logic signed [ACC_DW-1:0] xr, xi, tr, ti, pr, pi;
    logic signed [ACC_DW-1:0] acc_re, acc_im;
    logic signed [MW-1:0]     er, ei;
    logic [MW-1:0]            sq, mag, sh;
    logic [IW-1:0]            idx;
    logic [TAP_DW-1:0]        tap;

    // in[i] * conj(tap[i]) over this cycle's MULT_PAR taps
    always_comb begin
      pr = '0;
      pi = '0;
      xr = '0;
      xi = '0;
      tr = '0;
      ti = '0;
      idx = '0;
      tap = '0;
      for (int p = 0; p < MULT_PAR; p++) begin
        idx = IW'(k * MULT_PAR + p);
        tap = PSS_LOCAL[(s * PSS_LEN + int'(idx)) * TAP_DW +: TAP_DW];
        xr = ACC_DW'($signed(dline[idx][IH-1:0]));
        xi = ACC_DW'($signed(dline[idx][IN_DW-1:IH]));
        tr = ACC_DW'($signed(tap[TH-1:0]));
        ti = ACC_DW'($signed(tap[TAP_DW-1:TH]));
        pr = pr + xr * tr + xi * ti;
        pi = pi + xi * tr - xr * ti;
      end
    end

    assign er = MW'(acc_re);
    assign ei = MW'(acc_im);
    assign sq = $unsigned(er * er + ei * ei);
    assign sh = mag >> OUT_SHIFT;

    if (OUT_DW < MW) begin : g_sat
      assign sat[s] = (|sh[MW-1:OUT_DW]) ? '1 : sh[OUT_DW-1:0];
    end else begin : g_wide
      assign sat[s] = OUT_DW'(sh);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        acc_re <= '0;
        acc_im <= '0;
        mag <= '0;
      end else begin
        if (accept) begin
          acc_re <= '0;
          acc_im <= '0;
        end else if (state == MAC) begin
          acc_re <= acc_re + pr;
          acc_im <= acc_im + pi;
        end
        if (state == MAG) mag <= sq;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
      k <= '0;
      j <= '0;
      for (int i = 0; i < PSS_LEN; i++) dline[i] <= '0;
      m_axis_out_tdata <= '0;
      m_axis_out_tuser <= '0;
      m_axis_out_tlast <= 1'b0;
      m_axis_out_tvalid <= 1'b0;
    end else begin
      m_axis_out_tdata <= '0;
      m_axis_out_tuser <= '0;
      m_axis_out_tlast <= 1'b0;
      m_axis_out_tvalid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            for (int i = 0; i < PSS_LEN - 1; i++) dline[i] <= dline[i+1];
            dline[PSS_LEN-1] <= s_axis_in_tdata;
            k <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          k <= k + 1'b1;
          if (k == KW'(K - 1)) state <= MAG;
        end
        MAG: begin
          j <= '0;
          state <= OUT;
        end
        OUT: begin
          m_axis_out_tvalid <= 1'b1;
          m_axis_out_tdata <= sat[j];
          m_axis_out_tuser <= j;
          m_axis_out_tlast <= (j == UW'(NUM_SEQ - 1));
          if (j == UW'(NUM_SEQ - 1)) state <= IDLE;
          else j <= j + 1'b1;
        end
      endcase
    end
  end

endmodule
